// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the DMEM arbiter:
// FSM state encoding and DMEM width constants.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and DMEM-side signals of the DMEM arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_access_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_en;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_read_data,
    output ack0, rdata0, ack1, rdata1,
    output mem_access_addr, mem_write_data,
    output mem_write_en, mem_read, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_read_data,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_access_addr, mem_write_data,
    input  mem_write_en, mem_read, busy
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way picker; round-robin on ties
// unless fixed_prio_i forces port 0.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       fixed_prio_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = 1'b0;
    unique case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = fixed_prio_i ? 1'b0 : ~last_grant_i;
      default: gnt_id_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port DMEM arbiter: IDLE -> ACCESS -> RESP sequencer
// with registered mem_* strobes, ack pulses and read data.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  arb_state_e        state_q;
  logic              last_q;
  logic              id_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mwe_q;
  logic              mrd_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              busy_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] cap_d;

  rr_arb2 u_arb (
    .req_i        ({bus.req1, bus.req0}),
    .last_grant_i (last_q),
    .fixed_prio_i (FIXED_PRIO),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  always_comb begin
    we_d    = gnt_id ? bus.we1    : bus.we0;
    addr_d  = gnt_id ? bus.addr1  : bus.addr0;
    wdata_d = gnt_id ? bus.wdata1 : bus.wdata0;
    // writes report zero read data
    cap_d   = we_q ? '0 : bus.mem_read_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mwe_q    <= 1'b0;
      mrd_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            id_q    <= gnt_id;
            last_q  <= gnt_id;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mwe_q   <= we_d;
            mrd_q   <= ~we_d;
            busy_q  <= 1'b1;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (id_q) begin
            rdata1_q <= cap_d;
            ack1_q   <= 1'b1;
          end else begin
            rdata0_q <= cap_d;
            ack0_q   <= 1'b1;
          end
          addr_q  <= '0;
          wdata_q <= '0;
          mwe_q   <= 1'b0;
          mrd_q   <= 1'b0;
          state_q <= S_RESP;
        end
        S_RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_access_addr = addr_q;
  assign bus.mem_write_data  = wdata_q;
  assign bus.mem_write_en    = mwe_q;
  assign bus.mem_read        = mrd_q;
  assign bus.ack0            = ack0_q;
  assign bus.ack1            = ack1_q;
  assign bus.rdata0          = rdata0_q;
  assign bus.rdata1          = rdata1_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin and
// fixed-priority instances, each with a small DMEM model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if b0 ();
  dmem_arbiter_if b1 ();

  dmem_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  dmem_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  assign b0.mem_read_data = b0.mem_read ? mem0[b0.mem_access_addr] : 8'h00;
  assign b1.mem_read_data = b1.mem_read ? mem1[b1.mem_access_addr] : 8'h00;

  always @(posedge clk) begin
    if (b0.mem_write_en) mem0[b0.mem_access_addr] <= b0.mem_write_data;
    if (b1.mem_write_en) mem1[b1.mem_access_addr] <= b1.mem_write_data;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // one access on instance b0; returns in the following IDLE cycle
  task automatic txn(input bit p, input bit we, input logic [7:0] a,
                     input logic [7:0] d, output logic [7:0] rd);
    int n;
    bit got;
    if (p) begin
      b0.req1 = 1'b1; b0.we1 = we; b0.addr1 = a; b0.wdata1 = d;
    end else begin
      b0.req0 = 1'b1; b0.we0 = we; b0.addr0 = a; b0.wdata0 = d;
    end
    tick();
    chk("acc_we", {31'd0, b0.mem_write_en}, {31'd0, we});
    chk("acc_rd", {31'd0, b0.mem_read}, {31'd0, ~we});
    chk("acc_addr", {24'd0, b0.mem_access_addr}, {24'd0, a});
    if (we) chk("acc_wdata", {24'd0, b0.mem_write_data}, {24'd0, d});
    n = 1;
    got = 1'b0;
    while (!got && n < 6) begin
      tick();
      n++;
      got = p ? b0.ack1 : b0.ack0;
    end
    chk("latency", n, 2);
    chk("loser_ack", {31'd0, p ? b0.ack0 : b0.ack1}, 0);
    rd = p ? b0.rdata1 : b0.rdata0;
    b0.req0 = 1'b0;
    b0.req1 = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int prev, n0, n1, c0, c1, start, n0_at1;

    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[1] = 8'h11; mem0[2] = 8'h22;
    mem1[1] = 8'h11; mem1[2] = 8'h22;
    b0.req0 = 0; b0.we0 = 0; b0.addr0 = 8'h01; b0.wdata0 = 0;
    b0.req1 = 0; b0.we1 = 0; b0.addr1 = 8'h02; b0.wdata1 = 0;
    b1.req0 = 0; b1.we0 = 0; b1.addr0 = 8'h01; b1.wdata0 = 0;
    b1.req1 = 0; b1.we1 = 0; b1.addr1 = 8'h02; b1.wdata1 = 0;

    // reset held with both requests up
    rst = 1'b1;
    b0.req0 = 1'b1;
    b0.req1 = 1'b1;
    repeat (2) begin
      tick();
      chk("rst_ack", {30'd0, b0.ack1, b0.ack0}, 0);
      chk("rst_mem", {30'd0, b0.mem_read, b0.mem_write_en}, 0);
      chk("rst_busy", {31'd0, b0.busy}, 0);
      chk("rst_rdata", {16'd0, b0.rdata1, b0.rdata0}, 0);
    end
    rst = 1'b0;
    tick();
    chk("first_gnt_addr", {24'd0, b0.mem_access_addr}, 32'h01);
    chk("first_busy", {31'd0, b0.busy}, 1);
    tick();
    chk("first_ack", {30'd0, b0.ack1, b0.ack0}, 32'b01);
    chk("first_rdata", {24'd0, b0.rdata0}, 32'h11);
    b0.req0 = 1'b0;
    b0.req1 = 1'b0;
    tick();
    chk("idle_busy", {31'd0, b0.busy}, 0);

    // single write then read, plus top-address passthrough
    txn(1'b0, 1'b1, 8'h03, 8'hA5, rd);
    chk("wr_rdata_zero", {24'd0, rd}, 0);
    chk("mem3", {24'd0, mem0[3]}, 32'hA5);
    txn(1'b0, 1'b0, 8'h03, 8'h00, rd);
    chk("rd3", {24'd0, rd}, 32'hA5);
    txn(1'b0, 1'b1, 8'hFF, 8'h3C, rd);
    txn(1'b1, 1'b0, 8'hFF, 8'h00, rd);
    chk("rdFF_p1", {24'd0, rd}, 32'h3C);

    // contention: last winner was port 1, so order is 0,1,0,1
    b0.we0 = 0; b0.addr0 = 8'h01; b0.req0 = 1'b1;
    b0.we1 = 0; b0.addr1 = 8'h02; b0.req1 = 1'b1;
    prev = cyc;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 6; j++) begin
        tick();
        if (b0.ack0 || b0.ack1) break;
      end
      chk("rr_id", {31'd0, b0.ack1}, k % 2);
      chk("rr_both", {31'd0, b0.ack0 & b0.ack1}, 0);
      chk("rr_gap", cyc - prev, (k == 0) ? 2 : 3);
      if (k % 2 == 0) chk("rr_rdata0", {24'd0, b0.rdata0}, 32'h11);
      else            chk("rr_rdata1", {24'd0, b0.rdata1}, 32'h22);
      prev = cyc;
    end
    b0.req0 = 1'b0;
    b0.req1 = 1'b0;
    tick();

    // late arrival of port 1 during port 0's ACCESS
    b0.req0 = 1'b1;
    tick();
    b0.req1 = 1'b1;
    n0 = 0; n1 = 0; c0 = 0; c1 = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (b0.ack0) begin n0++; c0 = cyc; b0.req0 = 1'b0; end
      if (b0.ack1) begin n1++; c1 = cyc; b0.req1 = 1'b0; end
    end
    chk("late_n0", n0, 1);
    chk("late_n1", n1, 1);
    chk("late_gap", c1 - c0, 3);

    // reset lands on the ACCESS cycle of a port 1 write
    b0.we1 = 1'b1; b0.addr1 = 8'h04; b0.wdata1 = 8'h5A; b0.req1 = 1'b1;
    tick();
    chk("mid_we", {31'd0, b0.mem_write_en}, 1);
    rst = 1'b1;
    b0.req1 = 1'b0;
    tick();
    chk("mid_ack1", {31'd0, b0.ack1}, 0);
    chk("mid_busy", {31'd0, b0.busy}, 0);
    chk("mid_we_clr", {31'd0, b0.mem_write_en}, 0);
    rst = 1'b0;
    tick();
    chk("mid_ack1_post", {31'd0, b0.ack1}, 0);
    chk("mid_mem4", {24'd0, mem0[4]}, 32'h5A);
    txn(1'b0, 1'b0, 8'h04, 8'h00, rd);
    chk("rd4", {24'd0, rd}, 32'h5A);

    // fixed priority: port 1 waits until port 0 lets go
    b1.req0 = 1'b1;
    b1.req1 = 1'b1;
    start = cyc;
    n0 = 0; n1 = 0; c1 = 0; n0_at1 = -1;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (b1.ack0) begin
        n0++;
        if (n0 == 3) b1.req0 = 1'b0;
      end
      if (b1.ack1) begin
        n1++;
        c1 = cyc;
        n0_at1 = n0;
        b1.req1 = 1'b0;
      end
    end
    chk("fp_n0", n0, 3);
    chk("fp_n1", n1, 1);
    chk("fp_p1_after", n0_at1, 3);
    chk("fp_p1_time", c1 - start, 11);
    chk("fp_rdata1", {24'd0, b1.rdata1}, 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
